// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: shared types for the SPI flash read arbiter
package spi_mem_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
   typedef enum logic {PORT_IF, PORT_D} port_t;
   localparam int WORD_TAG_W = 15;
endpackage

// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: shares one SPI flash read engine between fetch and data ports, with a one-word read buffer
// Ports: clk_in/reset_n_in (sync, active-low); if_* fetch port and d_* data port (req/addr in, data/valid out);
// flush_in invalidates the buffer; mem_* connect to the flash controller (addr/addr_valid out, data/data_valid/busy in).
module spi_mem_arbiter
   import spi_mem_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk_in,
   input  logic        reset_n_in,
   input  logic        if_req_in,
   input  logic [15:0] if_addr_in,
   output logic [15:0] if_data_out,
   output logic        if_valid_out,
   input  logic        d_req_in,
   input  logic [15:0] d_addr_in,
   output logic [15:0] d_data_out,
   output logic        d_valid_out,
   input  logic        flush_in,
   output logic [15:0] mem_addr_out,
   output logic        mem_addr_valid_out,
   input  logic [15:0] mem_data_in,
   input  logic        mem_data_valid_in,
   input  logic        mem_busy_in
);
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
   arb_state_t state, state_nx;
   port_t port;
   logic [WORD_TAG_W-1:0] tag, buf_tag, sel_tag;
   logic [15:0] buf_data;
   logic buf_valid, if_win, grant, hit, fill, unused_addr_lsb;
   logic [3:0] starve_cnt;
   // data port wins unless the fetch port has been passed over STARVE_LIMIT times in a row
   assign if_win = if_req_in && (!d_req_in || starve_cnt == LIMIT);
   assign grant = if_req_in || d_req_in;
   assign sel_tag = if_win ? if_addr_in[15:1] : d_addr_in[15:1];
   assign hit = buf_valid && buf_tag == sel_tag;
   assign fill = state == WAIT && mem_data_valid_in;
   assign mem_addr_out = {tag, 1'b0};
   assign unused_addr_lsb = if_addr_in[0] ^ d_addr_in[0];
   always_ff @(posedge clk_in)
      state <= !reset_n_in ? IDLE : state_nx;
   always_comb begin
      state_nx = state;
      mem_addr_valid_out = 1'b0;
      if_valid_out = 1'b0;
      d_valid_out = 1'b0;
      case (state)
         IDLE: state_nx = !grant ? IDLE : hit ? DONE : ISSUE;
         ISSUE: begin
            mem_addr_valid_out = !mem_busy_in;
            state_nx = mem_busy_in ? ISSUE : WAIT;
         end
         WAIT: state_nx = mem_data_valid_in ? DONE : WAIT;
         DONE: begin
            if_valid_out = port == PORT_IF;
            d_valid_out = port == PORT_D;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk_in) begin
      if (!reset_n_in) begin
         port <= PORT_IF;
         tag <= '0;
         buf_tag <= '0;
         buf_data <= '0;
         buf_valid <= 1'b0;
         starve_cnt <= '0;
         if_data_out <= '0;
         d_data_out <= '0;
      end else begin
         if (state == IDLE && grant) begin
            port <= if_win ? PORT_IF : PORT_D;
            tag <= sel_tag;
            if (hit && if_win) if_data_out <= buf_data;
            if (hit && !if_win) d_data_out <= buf_data;
         end
         if (fill) begin
            if (port == PORT_IF) if_data_out <= mem_data_in;
            else d_data_out <= mem_data_in;
            buf_data <= mem_data_in;
            buf_tag <= tag;
         end
         // flush beats a same-cycle fill: the port still gets its data but the buffer stays invalid
         buf_valid <= flush_in ? 1'b0 : fill ? 1'b1 : buf_valid;
         starve_cnt <= (!if_req_in || (state == IDLE && if_win)) ? '0 :
                       (state == IDLE && grant && starve_cnt != LIMIT) ? starve_cnt + 4'd1 : starve_cnt;
      end
   end
endmodule

// File: tb/tb_spi_mem_arbiter.sv
// tb_spi_mem_arbiter: randomized check of spi_mem_arbiter against a transaction-level buffer/arbitration model
module tb_spi_mem_arbiter;
   localparam int LIMIT = 4;
   logic clk = 1'b0, reset_n = 1'b0;
   logic if_req = 1'b0, d_req = 1'b0, flush_drv = 1'b0, fill_flush = 1'b0;
   logic [15:0] if_addr = '0, d_addr = '0;
   logic [15:0] if_data, d_data, mem_addr, mem_data, fl_addr, last_mem_addr;
   logic if_valid, d_valid, mem_addr_valid, mem_data_valid, mem_busy, flush;
   int n_chk = 0, n_err = 0, issues = 0, fl_cnt;
   logic bv = 1'b0;
   logic [14:0] bt = '0;
   always #5 clk = ~clk;
   assign flush = flush_drv | (fill_flush & mem_data_valid);
   spi_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk_in(clk), .reset_n_in(reset_n),
      .if_req_in(if_req), .if_addr_in(if_addr), .if_data_out(if_data), .if_valid_out(if_valid),
      .d_req_in(d_req), .d_addr_in(d_addr), .d_data_out(d_data), .d_valid_out(d_valid),
      .flush_in(flush), .mem_addr_out(mem_addr), .mem_addr_valid_out(mem_addr_valid),
      .mem_data_in(mem_data), .mem_data_valid_in(mem_data_valid), .mem_busy_in(mem_busy)
   );
   function automatic logic [15:0] mem_word(input logic [14:0] w);
      return w == 15'h8 ? 16'hBEEF : (16'({1'b0, w}) * 16'h9E37) ^ 16'h5A5A;
   endfunction
   function automatic logic [15:0] rnd_addr();
      return {15'($urandom_range(5, 12)), 1'($urandom_range(0, 1))};
   endfunction
   always @(posedge clk) begin
      if (!reset_n) begin
         mem_busy <= 1'b0;
         mem_data_valid <= 1'b0;
         mem_data <= '0;
         fl_addr <= '0;
         last_mem_addr <= '0;
      end else begin
         mem_data_valid <= 1'b0;
         if (mem_busy) begin
            if (fl_cnt == 0) begin
               mem_busy <= 1'b0;
               mem_data_valid <= 1'b1;
               mem_data <= mem_word(fl_addr[15:1]);
            end else fl_cnt <= fl_cnt - 1;
         end else if (mem_addr_valid) begin
            mem_busy <= 1'b1;
            fl_addr <= mem_addr;
            last_mem_addr <= mem_addr;
            fl_cnt <= $urandom_range(3, 12);
            issues <= issues + 1;
         end
      end
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic do_flush();
      @(negedge clk);
      flush_drv = 1'b1;
      @(negedge clk);
      flush_drv = 1'b0;
      bv = 1'b0;
   endtask
   task automatic do_req(input logic p, input logic [15:0] a);
      int lat, iss0;
      logic [15:0] got, other;
      logic [14:0] w;
      logic hit, done;
      lat = 0;
      got = '0;
      done = 1'b0;
      w = a[15:1];
      hit = bv && bt == w;
      @(negedge clk);
      iss0 = issues;
      other = p ? if_data : d_data;
      if (p) begin d_req = 1'b1; d_addr = a; end
      else begin if_req = 1'b1; if_addr = a; end
      while (!done && lat < 400) begin
         @(negedge clk);
         lat++;
         if (p ? d_valid : if_valid) begin
            done = 1'b1;
            got = p ? d_data : if_data;
         end
      end
      if_req = 1'b0;
      d_req = 1'b0;
      chk("done", 32'(done), 1);
      chk("data", 32'(got), 32'(mem_word(w)));
      chk("issued", issues - iss0, hit ? 0 : 1);
      chk("other_hold", 32'(p ? if_data : d_data), 32'(other));
      if (hit) chk("hit_lat", lat, 1);
      else chk("miss_addr", 32'(last_mem_addr), 32'({w, 1'b0}));
      @(negedge clk);
      chk("pulse_width", 32'(p ? d_valid : if_valid), 0);
      bv = hit || !fill_flush;
      bt = w;
   endtask
   task automatic run_both(input int nd, input int ni, input logic [15:0] ad, input logic [15:0] ai);
      int cnt, miss, iss0, cyc, rd, ri;
      logic [14:0] w;
      logic exp_d;
      cnt = 0;
      miss = 0;
      cyc = 0;
      rd = nd;
      ri = ni;
      @(negedge clk);
      iss0 = issues;
      d_addr = ad;
      if_addr = ai;
      d_req = rd > 0;
      if_req = ri > 0;
      while ((rd > 0 || ri > 0) && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         if (d_valid || if_valid) begin
            exp_d = rd > 0 && (ri == 0 || cnt < LIMIT);
            chk("grant_port", 32'(d_valid), 32'(exp_d));
            w = d_valid ? d_addr[15:1] : if_addr[15:1];
            miss += (bv && bt == w) ? 0 : 1;
            bv = 1'b1;
            bt = w;
            chk("grant_data", 32'(d_valid ? d_data : if_data), 32'(mem_word(w)));
            if (d_valid) begin
               cnt = ri > 0 ? cnt + 1 : 0;
               rd--;
               d_req = rd > 0;
               d_addr = rnd_addr();
            end else begin
               cnt = 0;
               ri--;
               if_req = ri > 0;
               if_addr = rnd_addr();
            end
         end
      end
      d_req = 1'b0;
      if_req = 1'b0;
      chk("both_done", rd + ri, 0);
      chk("both_issues", issues - iss0, miss);
   endtask
   task automatic chk_reset_outputs();
      chk("rst_if_data", 32'(if_data), 0);
      chk("rst_d_data", 32'(d_data), 0);
      chk("rst_if_valid", 32'(if_valid), 0);
      chk("rst_d_valid", 32'(d_valid), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_addr_valid", 32'(mem_addr_valid), 0);
   endtask
   initial begin
      int cyc;
      repeat (3) @(negedge clk);
      chk_reset_outputs();
      reset_n = 1'b1;
      do_req(1'b0, 16'h0011);
      do_req(1'b0, 16'h0010);
      do_flush();
      do_req(1'b0, 16'h0010);
      fill_flush = 1'b1;
      do_req(1'b1, 16'h0020);
      fill_flush = 1'b0;
      do_req(1'b1, 16'h0020);
      do_flush();
      run_both(1, 1, 16'h0040, 16'h0041);
      do_flush();
      run_both(12, 3, rnd_addr(), rnd_addr());
      do_flush();
      @(negedge clk);
      if_req = 1'b1;
      if_addr = 16'h0030;
      cyc = 0;
      while (!mem_busy && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      chk("reached_wait", 32'(mem_busy), 1);
      reset_n = 1'b0;
      if_req = 1'b0;
      @(negedge clk);
      chk_reset_outputs();
      reset_n = 1'b1;
      bv = 1'b0;
      do_req(1'b0, 16'h0030);
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 5) == 0) do_flush();
         fill_flush = $urandom_range(0, 7) == 0;
         do_req(1'($urandom_range(0, 1)), rnd_addr());
         fill_flush = 1'b0;
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule

// File: doc/spi_mem_arbiter.md
# spi_mem_arbiter

Two-port read arbiter sitting in front of `spi_flash_controller`. It shares the single SPI flash read engine between the CPU instruction-fetch port and the data-load port. It also holds a one-word read buffer so that back-to-back reads of the same 16-bit word skip the SPI transaction. The flash controller's active-high reset is tied to `~reset_n_in` at the top level.

## Interface
- `STARVE_LIMIT`, default 4: maximum consecutive data-port grants while a fetch request is pending; range 1..15.
- `clk_in`  in  1  system clock
- `reset_n_in`  in  1  one clock; reset is synchronous and active-low
- `if_req_in`  in  1  fetch request; held high until `if_valid_out`
- `if_addr_in`  in  16  fetch byte address; bit 0 ignored; stable while `if_req_in`
- `if_data_out`  out  16  fetch read data; [15:8]=odd byte, [7:0]=even byte
- `if_valid_out`  out  1  one-cycle fetch completion pulse
- `d_req_in`  in  1  data-load request; same rules as fetch
- `d_addr_in`  in  16  data byte address; bit 0 ignored
- `d_data_out`  out  16  load read data
- `d_valid_out`  out  1  one-cycle load completion pulse
- `flush_in`  in  1  invalidates the word buffer
- `mem_addr_out`  out  16  to flash controller `addr_in`
- `mem_addr_valid_out`  out  1  to flash controller `addr_valid_in`; single-cycle pulse
- `mem_data_in`  in  16  from flash controller `data_out`
- `mem_data_valid_in`  in  1  from flash controller `data_valid_out`
- `mem_busy_in`  in  1  from flash controller `busy_out`

## Operation
- States:
  - IDLE: arbitrate.
  - ISSUE: launch the SPI read.
  - WAIT: await flash data.
  - DONE: drive the completion pulse.
- Arbitration in IDLE:
  - Data port wins over fetch.
  - Exception: fetch wins when `starve_cnt == STARVE_LIMIT` and `if_req_in` is high.
  - `starve_cnt` increments on each data grant while `if_req_in` is high, saturating at `STARVE_LIMIT`.
  - `starve_cnt` clears on any fetch grant, and whenever `if_req_in` is low.
- On grant, latch the port id and `addr[15:1]`.
- Buffer hit: `buf_valid` set and tag == `addr[15:1]` → load `buf_data` to the port's data output and go to DONE.
- Buffer miss: go to ISSUE.
- ISSUE:
  - `mem_addr_valid_out = (state==ISSUE) && !mem_busy_in` (combinational).
  - Go to WAIT in the cycle it is asserted.
  - `mem_addr_out = {tag, 1'b0}`.
- WAIT:
  - On `mem_data_valid_in`, register `mem_data_in` into the granted port's data output and into `buf_data`.
  - Set tag and `buf_valid`, then go to DONE.
  - `mem_data_valid_in` is ignored in every state except WAIT.
- DONE:
  - Granted port's `*_valid_out` is high for exactly this cycle.
  - Both `*_req_in` are ignored this cycle, so a still-high request is not re-served; the requester drops or changes its request next cycle.
  - Next state is IDLE.
- `*_data_out` holds its last value between completions.
- `flush_in` clears `buf_valid` in any state.
  - If asserted in the same cycle as a WAIT fill, flush wins: the buffer is left invalid, but the port still receives the data.
- Reset mid-transaction: the arbiter returns to IDLE. The flash controller resets in the same cycle, so no stale completion can arrive.

## Timing
- Reset values:
  - state = IDLE
  - `if_data_out` = `d_data_out` = 0
  - `if_valid_out` = `d_valid_out` = 0
  - `mem_addr_out` = 0, `mem_addr_valid_out` = 0
  - `buf_valid` = 0, `starve_cnt` = 0
- Hit latency: request sampled in IDLE at cycle T → `*_valid_out` at T+1 → IDLE at T+2.
- Miss latency:
  - Request at T → `mem_addr_valid_out` at T+1 if flash idle.
  - Completion pulse one cycle after `mem_data_valid_in`.
  - Total is about 100 cycles (48 SPI clock periods of 2 cycles each, plus overhead).
- Back-to-back: a new grant is possible every 2 cycles on hits, i.e. one IDLE cycle per request.
- Both requests pending with equal address: data is served first; fetch then hits the buffer.

## Structure
- Package `spi_mem_pkg`:
  - `arb_state_t` enum {IDLE, ISSUE, WAIT, DONE}
  - `port_t` enum {PORT_IF, PORT_D}
  - `WORD_TAG_W = 15`
- No sub-module; arbitration, starvation counter and word buffer live in one file.
- `spi_flash_controller` is instantiated beside this block at the top, not inside it.

## Test plan
- Single fetch miss, flash model holds 0xBEEF at 0x0010/0x0011:
  - `if_addr_in=0x0011` → `mem_addr_out=0x0010` pulses once.
  - `if_data_out=0xBEEF`, `if_valid_out` high for 1 cycle.
- Repeat the same fetch at 0x0010 → no `mem_addr_valid_out`; `if_valid_out` 1 cycle after request with 0xBEEF.
- `flush_in` pulse, then the same fetch → a new SPI read is issued.
- Flush coinciding with a fill → data delivered, and the next same-address read misses.
- `d_req_in` and `if_req_in` held continuously on distinct addresses, `STARVE_LIMIT=4` → grant order D,D,D,D,IF,D,…; no port waits more than 5 grants.
- Assert `reset_n_in` low during WAIT:
  - Next cycle all outputs are at reset values and state is IDLE.
  - A fresh request after reset completes correctly.
